fetch_sequencer: RTL and testbench

Sequences the instruction-fetch stage of the pipelined core. It owns the program counter and talks to a variable-latency instruction memory with a request/valid handshake. It also applies branch redirects (PCSrcE/PCTargetE) and decode stalls (StallD), and drives the IF/ID pipeline register (InstrD, PCD, PCPlus4D) plus a valid flag. It sits between the hazard/execute logic and the instruction memory and replaces the free-running PC/mux/adder arrangement.

---
 rtl/fetch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request/valid handshake and drives IF/ID.
// Defining FETCH_SEQ_PERF_EN builds the fetch/stall performance counters; otherwise both read as zero.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] redir_pc, redir_pc_n;
  logic [31:0] hold_instr, hold_instr_n;
  logic [31:0] hold_pc, hold_pc_n;
  logic [31:0] instr_n, pcd_n, pcplus4d_n;
  logic        valid_n;
  logic        fetching;
  logic        done;
  logic        deliver;
  logic [31:0] load_instr, load_pc;

  // A request is outstanding in FETCH and DISCARD; HOLD parks the pipeline without a request.
  assign fetching  = (state != HOLD);
  assign done      = fetching && imem_rvalid;
  assign imem_req  = reset && fetching;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      redir_pc   <= RESET_PC;
      hold_instr <= NOP_INSTR;
      hold_pc    <= 32'h0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      redir_pc   <= redir_pc_n;
      hold_instr <= hold_instr_n;
      hold_pc    <= hold_pc_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD   <= NOP_INSTR;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else begin
      InstrD   <= instr_n;
      PCD      <= pcd_n;
      PCPlus4D <= pcplus4d_n;
      ValidD   <= valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    redir_pc_n   = redir_pc;
    hold_instr_n = hold_instr;
    hold_pc_n    = hold_pc;
    deliver      = 1'b0;
    load_instr   = imem_rdata;
    load_pc      = pc;

    case (state)
      FETCH: begin
        if (done) begin
          if (PCSrcE) begin
            pc_n = PCTargetE;
          end else if (StallD) begin
            hold_instr_n = imem_rdata;
            hold_pc_n    = pc;
            pc_n         = pc + 32'd4;
            state_n      = HOLD;
          end else begin
            deliver = 1'b1;
            pc_n    = pc + 32'd4;
          end
        end else if (PCSrcE) begin
          redir_pc_n = PCTargetE;
          state_n    = DISCARD;
        end
      end
      // The stale request must finish before the redirect target can be issued.
      DISCARD: begin
        if (done) begin
          pc_n    = PCSrcE ? PCTargetE : redir_pc;
          state_n = FETCH;
        end else if (PCSrcE) begin
          redir_pc_n = PCTargetE;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pc_n    = PCTargetE;
          state_n = FETCH;
        end else if (!StallD) begin
          deliver    = 1'b1;
          load_instr = hold_instr;
          load_pc    = hold_pc;
          state_n    = FETCH;
        end
      end
      default: begin
        state_n = FETCH;
      end
    endcase

    // IF/ID priority: flush, then hold, then load (a bubble when nothing arrived).
    instr_n    = NOP_INSTR;
    pcd_n      = 32'h0;
    pcplus4d_n = 32'h0;
    valid_n    = 1'b0;
    if (!PCSrcE && StallD) begin
      instr_n    = InstrD;
      pcd_n      = PCD;
      pcplus4d_n = PCPlus4D;
      valid_n    = ValidD;
    end else if (deliver) begin
      instr_n    = load_instr;
      pcd_n      = load_pc;
      pcplus4d_n = load_pc + 32'd4;
      valid_n    = 1'b1;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] fetch_cnt, stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= 32'h0;
      stall_cnt <= 32'h0;
    end else begin
      if (deliver) fetch_cnt <= fetch_cnt + 32'd1;
      if ((fetching && !imem_rvalid) || (state == HOLD)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt;
  assign stall_count = stall_cnt;
`else
  assign fetch_count = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized run
// against a transaction-level reference model (held-instruction queue, drop flag).
module tb_fetch_sequencer;

`ifdef FETCH_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [31:0] fetch_count, stall_count;

  logic        w_req;
  logic [31:0] w_addr, w_InstrD, w_PCD, w_PCPlus4D, w_fetch, w_stall;
  logic        w_ValidD;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] data_xor = 32'h0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_t;

  // reference model state
  bit          m_run;
  logic [31:0] m_addr;
  bit          m_drop;
  logic [31:0] m_drop_tgt;
  fetch_t      m_held[$];
  logic [31:0] m_instr, m_pc, m_pc4;
  logic        m_valid;
  logic [31:0] m_fcnt, m_scnt;

  fetch_sequencer dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(1'b1), .imem_rdata(w_addr),
    .PCSrcE(1'b0), .PCTargetE(32'h0), .StallD(1'b0),
    .InstrD(w_InstrD), .PCD(w_PCD), .PCPlus4D(w_PCPlus4D), .ValidD(w_ValidD),
    .fetch_count(w_fetch), .stall_count(w_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [31:0] perf(input logic [31:0] v);
    return PERF ? v : 32'h0;
  endfunction

  task automatic model_bubble();
    m_instr = NOP; m_pc = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_run = 1'b1; m_addr = 32'h0; m_drop = 1'b0; m_drop_tgt = 32'h0;
    m_held.delete();
    model_bubble();
    m_fcnt = 32'h0; m_scnt = 32'h0;
  endtask

  // One clock of the fetch rules, expressed over transactions rather than FSM states.
  task automatic model_step(input logic rv, input logic br, input logic [31:0] tgt, input logic st);
    bit req, done;
    fetch_t e;
    req  = m_run && (m_held.size() == 0);
    done = req && rv;
    if ((req && !rv) || m_held.size() != 0) m_scnt = m_scnt + 1;
    if (m_held.size() != 0) begin
      if (br) begin
        m_held.delete(); m_addr = tgt; model_bubble();
      end else if (!st) begin
        e = m_held.pop_front();
        m_instr = e.instr; m_pc = e.pc; m_pc4 = e.pc + 32'd4; m_valid = 1'b1;
        m_fcnt = m_fcnt + 1;
      end
    end else if (m_drop) begin
      if (done) begin
        m_addr = br ? tgt : m_drop_tgt; m_drop = 1'b0;
      end else if (br) m_drop_tgt = tgt;
      if (br || !st) model_bubble();
    end else begin
      if (done && br) begin
        m_addr = tgt; model_bubble();
      end else if (done && st) begin
        e.instr = m_addr ^ data_xor; e.pc = m_addr;
        m_held.push_back(e); m_addr = m_addr + 32'd4;
      end else if (done) begin
        m_instr = m_addr ^ data_xor; m_pc = m_addr; m_pc4 = m_addr + 32'd4; m_valid = 1'b1;
        m_fcnt = m_fcnt + 1; m_addr = m_addr + 32'd4;
      end else if (br) begin
        m_drop = 1'b1; m_drop_tgt = tgt; model_bubble();
      end else if (!st) model_bubble();
    end
  endtask

  // Called at a falling edge: applies one cycle of inputs and advances to the next falling edge.
  task automatic drive(input logic rv, input logic br, input logic [31:0] tgt, input logic st);
    imem_rvalid = rv;
    imem_rdata  = imem_addr ^ data_xor;
    PCSrcE      = br;
    PCTargetE   = tgt;
    StallD      = st;
    model_step(rv, br, tgt, st);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    imem_rvalid = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    imem_rvalid = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (imem_req !== 1'b0) $display("[TB] FAIL rst_req got %b exp 0", imem_req); else n_pass++;
    n_checks++; if (InstrD !== NOP) $display("[TB] FAIL rst_instr got %h exp %h", InstrD, NOP); else n_pass++;
    n_checks++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) $display("[TB] FAIL rst_pcd got %h/%h exp 0/0", PCD, PCPlus4D); else n_pass++;
    n_checks++; if (ValidD !== 1'b0) $display("[TB] FAIL rst_valid got %b exp 0", ValidD); else n_pass++;
    n_checks++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) $display("[TB] FAIL rst_cnt got %h/%h exp 0/0", fetch_count, stall_count); else n_pass++;
    @(negedge clk);
    imem_rvalid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("[TB] FAIL rst_first_req got %b@%h exp 1@00000000", imem_req, imem_addr); else n_pass++;
  endtask

  task automatic test_zero_wait();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      n_checks++; if (InstrD !== 32'(4*k) || PCD !== 32'(4*k) || PCPlus4D !== 32'(4*k+4) || ValidD !== 1'b1)
        $display("[TB] FAIL zw_idd%0d got %h/%h/%h/%b exp %h/%h/%h/1", k, InstrD, PCD, PCPlus4D, ValidD, 32'(4*k), 32'(4*k), 32'(4*k+4));
      else n_pass++;
    end
    n_checks++; if (fetch_count !== perf(32'd3)) $display("[TB] FAIL zw_fetch_count got %0d exp %0d", fetch_count, perf(32'd3)); else n_pass++;
  endtask

  task automatic test_wait_states();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 2; w++) begin
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*i) || ValidD !== 1'b0)
          $display("[TB] FAIL ws_wait%0d_%0d got req %b addr %h valid %b exp 1 %h 0", i, w, imem_req, imem_addr, ValidD, 32'(4*i));
        else n_pass++;
      end
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      n_checks++; if (InstrD !== 32'(4*i) || ValidD !== 1'b1)
        $display("[TB] FAIL ws_done%0d got %h/%b exp %h/1", i, InstrD, ValidD, 32'(4*i));
      else n_pass++;
    end
    n_checks++; if (stall_count !== perf(32'd6) || fetch_count !== perf(32'd3))
      $display("[TB] FAIL ws_counts got %0d/%0d exp %0d/%0d", stall_count, fetch_count, perf(32'd6), perf(32'd3));
    else n_pass++;
  endtask

  task automatic test_redirect();
    apply_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || ValidD !== 1'b0)
      $display("[TB] FAIL rd_discard got req %b addr %h valid %b exp 1 00000008 0", imem_req, imem_addr, ValidD);
    else n_pass++;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++; if (imem_addr !== 32'h40 || ValidD !== 1'b0 || InstrD !== NOP)
      $display("[TB] FAIL rd_drop got addr %h valid %b instr %h exp 00000040 0 %h", imem_addr, ValidD, InstrD, NOP);
    else n_pass++;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++; if (InstrD !== 32'h40 || PCD !== 32'h40 || ValidD !== 1'b1)
      $display("[TB] FAIL rd_target got %h/%h/%b exp 00000040/00000040/1", InstrD, PCD, ValidD);
    else n_pass++;
    drive(1'b1, 1'b1, 32'h80, 1'b0);
    n_checks++; if (ValidD !== 1'b0 || imem_addr !== 32'h80)
      $display("[TB] FAIL rd_zw_bubble got valid %b addr %h exp 0 00000080", ValidD, imem_addr);
    else n_pass++;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++; if (InstrD !== 32'h80 || ValidD !== 1'b1)
      $display("[TB] FAIL rd_zw_target got %h/%b exp 00000080/1", InstrD, ValidD);
    else n_pass++;
  endtask

  task automatic test_stall_hold();
    apply_reset();
    repeat (4) drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      drive(s == 0, 1'b0, 32'h0, 1'b1);
      n_checks++; if (imem_req !== 1'b0 || InstrD !== 32'hC || ValidD !== 1'b1)
        $display("[TB] FAIL st_hold%0d got req %b instr %h valid %b exp 0 0000000c 1", s, imem_req, InstrD, ValidD);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (InstrD !== 32'h10 || PCD !== 32'h10 || ValidD !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h14)
      $display("[TB] FAIL st_release got %h/%h/%b req %b addr %h exp 00000010/00000010/1 1 00000014", InstrD, PCD, ValidD, imem_req, imem_addr);
    else n_pass++;
    n_checks++; if (stall_count !== perf(32'd3)) $display("[TB] FAIL st_stall_count got %0d exp %0d", stall_count, perf(32'd3)); else n_pass++;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++; if (InstrD !== 32'h14) $display("[TB] FAIL st_resume got %h exp 00000014", InstrD); else n_pass++;
  endtask

  task automatic test_hold_redirect();
    apply_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h100, 1'b1);
    n_checks++; if (ValidD !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      $display("[TB] FAIL hr_flush got valid %b instr %h pcd %h req %b addr %h exp 0 %h 0 1 00000100", ValidD, InstrD, PCD, imem_req, imem_addr, NOP);
    else n_pass++;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++; if (InstrD !== 32'h100 || PCD !== 32'h100 || ValidD !== 1'b1)
      $display("[TB] FAIL hr_target got %h/%h/%b exp 00000100/00000100/1", InstrD, PCD, ValidD);
    else n_pass++;
  endtask

  task automatic test_reset_wrap();
    apply_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || InstrD !== NOP || PCD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0)
      $display("[TB] FAIL mr_async got req %b %h/%h/%h/%b exp 0 %h/0/0/0", imem_req, InstrD, PCD, PCPlus4D, ValidD, NOP);
    else n_pass++;
    n_checks++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) $display("[TB] FAIL mr_cnt got %h/%h exp 0/0", fetch_count, stall_count); else n_pass++;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    n_checks++; if (InstrD !== NOP || ValidD !== 1'b0 || w_req !== 1'b0)
      $display("[TB] FAIL mr_late_rvalid got %h/%b wreq %b exp %h/0 0", InstrD, ValidD, w_req, NOP);
    else n_pass++;
    @(negedge clk);
    imem_rvalid = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++; if (imem_addr !== 32'h0 || w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC)
      $display("[TB] FAIL wr_first got addr %h waddr %h wreq %b exp 00000000 fffffffc 1", imem_addr, w_addr, w_req);
    else n_pass++;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++; if (w_addr !== 32'h0 || w_InstrD !== 32'hFFFF_FFFC || w_PCD !== 32'hFFFF_FFFC || w_PCPlus4D !== 32'h0 || w_ValidD !== 1'b1)
      $display("[TB] FAIL wr_wrap got addr %h instr %h pcd %h pc4 %h valid %b exp 0 fffffffc fffffffc 0 1", w_addr, w_InstrD, w_PCD, w_PCPlus4D, w_ValidD);
    else n_pass++;
  endtask

  task automatic test_random();
    data_xor = 32'h5A5A_A5A5;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if (n_checks - n_pass > 20) break;
      n_checks++; if (imem_req !== (m_held.size() == 0))
        $display("[TB] FAIL rnd_req cyc %0d got %b exp %b", c, imem_req, (m_held.size() == 0));
      else n_pass++;
      if (m_held.size() == 0) begin
        n_checks++; if (imem_addr !== m_addr) $display("[TB] FAIL rnd_addr cyc %0d got %h exp %h", c, imem_addr, m_addr); else n_pass++;
      end
      n_checks++; if (InstrD !== m_instr || PCD !== m_pc || PCPlus4D !== m_pc4 || ValidD !== m_valid)
        $display("[TB] FAIL rnd_ifid cyc %0d got %h/%h/%h/%b exp %h/%h/%h/%b", c, InstrD, PCD, PCPlus4D, ValidD, m_instr, m_pc, m_pc4, m_valid);
      else n_pass++;
      n_checks++; if (fetch_count !== perf(m_fcnt) || stall_count !== perf(m_scnt))
        $display("[TB] FAIL rnd_cnt cyc %0d got %0d/%0d exp %0d/%0d", c, fetch_count, stall_count, perf(m_fcnt), perf(m_scnt));
      else n_pass++;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), $urandom, 1'($urandom_range(0, 3) == 0));
    end
    data_xor = 32'h0;
  endtask

  initial begin
    reset = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    PCSrcE = 1'b0; PCTargetE = 32'h0; StallD = 1'b0;
    model_reset();
    m_run = 1'b0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_redirect();
    test_stall_hold();
    test_hold_redirect();
    test_reset_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
